// File: rtl/digital_port_irq_pkg.sv
// Shared constants for the digital_port_irq block: register map and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package digital_port_irq_pkg;

  localparam int DEFAULT_WIDTH         = 32;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_DEBOUNCE_BITS = 16;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_LEVEL    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DEBOUNCE = 3'd4;

endpackage

// File: rtl/digital_port_irq_if.sv
// Register bus in the DigitalPort chipSelect/writeEnable/dataIn/dataOut style.
// Latency: writes land on the clk edge they are presented; reads are combinational.
// Backpressure: none; every access completes in the cycle it is issued.
interface digital_port_irq_if;
  import digital_port_irq_pkg::*;

  logic              chipSelect;
  logic              writeEnable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;

  modport master (output chipSelect, writeEnable, address, dataIn, input dataOut);
  modport slave  (input chipSelect, writeEnable, address, dataIn, output dataOut);

endinterface

// File: rtl/digital_port_irq_port_sync_debounce.sv
// Synchronises raw pins into clk and optionally debounces them into a stable vector.
// Latency: SYNC_STAGES cycles bypassed; up to SYNC_STAGES + 2N + 1 with debounce N.
// Backpressure: none; free-running pipeline, stableNext is the value stable takes next edge.
module port_sync_debounce #(
  parameter int WIDTH         = 32,
  parameter int SYNC_STAGES   = 2,   // must be at least 2
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DEBOUNCE_BITS-1:0] debounceVal,
  input  logic                     prescalerClr,
  input  logic [WIDTH-1:0]         ioIn,
  output logic [WIDTH-1:0]         stable,
  output logic [WIDTH-1:0]         stableNext
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] syncChain;
  logic [WIDTH-1:0]                  syncOut;
  logic [WIDTH-1:0]                  sample;
  logic [WIDTH-1:0]                  agree;
  logic [DEBOUNCE_BITS-1:0]          prescaler;
  logic                              debounceOn;
  logic                              tick;

  assign syncOut    = syncChain[SYNC_STAGES-1];
  assign debounceOn = (debounceVal != '0);
  assign tick       = debounceOn && (prescaler == debounceVal - 1'b1);
  assign agree      = ~(syncOut ^ sample);

  // Metastability chain: shift raw pins in at stage 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) syncChain <= '0;
    else        syncChain <= {syncChain[SYNC_STAGES-2:0], ioIn};
  end

  // Prescaler counts 0..N-1 and wraps on the tick; held at 0 when bypassed or reprogrammed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 prescaler <= '0;
    else if (prescalerClr || !debounceOn || tick) prescaler <= '0;
    else                                        prescaler <= prescaler + 1'b1;
  end

  // Tick-rate snapshot of the synchronised pins, compared against the next tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sample <= '0;
    else if (tick)  sample <= syncOut;
  end

  // Next stable value: follow syncOut directly when bypassed, else only bits two ticks agree on.
  always_comb begin
    stableNext = stable;
    if (!debounceOn)  stableNext = syncOut;
    else if (tick)    stableNext = (stable & ~agree) | (syncOut & agree);
  end

  // Debounced pin state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stable <= '0;
    else        stable <= stableNext;
  end

endmodule

// File: rtl/digital_port_irq.sv
// Edge-detecting pin interrupt controller with sticky PENDING flags and a level irq.
// Latency: PENDING/irq update on the same edge as LEVEL; irq adds no cycle over PENDING.
// Backpressure: none; register bus accesses always complete in one cycle.
module digital_port_irq
  import digital_port_irq_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,        // at most DATA_W
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS // at most DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  digital_port_irq_if.slave    bus,
  input  logic [WIDTH-1:0]     ioIn,
  output logic                 irq
);

  logic [WIDTH-1:0]         stable;
  logic [WIDTH-1:0]         stableNext;
  logic [WIDTH-1:0]         riseEn;
  logic [WIDTH-1:0]         fallEn;
  logic [WIDTH-1:0]         pending;
  logic [WIDTH-1:0]         w1cMask;
  logic [WIDTH-1:0]         rise;
  logic [WIDTH-1:0]         fall;
  logic [DEBOUNCE_BITS-1:0] debounceReg;
  logic                     writeHit;

  assign writeHit = bus.chipSelect & bus.writeEnable;
  assign w1cMask  = (writeHit && bus.address == ADDR_PENDING) ? bus.dataIn[WIDTH-1:0] : '0;
  assign rise     = stableNext & ~stable;
  assign fall     = ~stableNext & stable;
  assign irq      = |pending;

  port_sync_debounce #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_sync (
    .clk          (clk),
    .reset        (reset),
    .debounceVal  (debounceReg),
    .prescalerClr (writeHit && bus.address == ADDR_DEBOUNCE),
    .ioIn         (ioIn),
    .stable       (stable),
    .stableNext   (stableNext)
  );

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      riseEn      <= '0;
      fallEn      <= '0;
      debounceReg <= '0;
    end else if (writeHit) begin
      if (bus.address == ADDR_RISE_EN)  riseEn      <= bus.dataIn[WIDTH-1:0];
      if (bus.address == ADDR_FALL_EN)  fallEn      <= bus.dataIn[WIDTH-1:0];
      if (bus.address == ADDR_DEBOUNCE) debounceReg <= bus.dataIn[DEBOUNCE_BITS-1:0];
    end
  end

  // Sticky pending flags: W1C clear first, then new enabled edges set, so a same-cycle edge wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~w1cMask) | (rise & riseEn) | (fall & fallEn);
  end

  // Side-effect-free read mux; idle bus reads as 0.
  always_comb begin
    bus.dataOut = '0;
    if (bus.chipSelect) begin
      case (bus.address)
        ADDR_LEVEL:    bus.dataOut = DATA_W'(stable);
        ADDR_RISE_EN:  bus.dataOut = DATA_W'(riseEn);
        ADDR_FALL_EN:  bus.dataOut = DATA_W'(fallEn);
        ADDR_PENDING:  bus.dataOut = DATA_W'(pending);
        ADDR_DEBOUNCE: bus.dataOut = DATA_W'(debounceReg);
        default:       bus.dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_port_irq.sv
// Directed self-checking bench for digital_port_irq with hand-computed expectations.
// Latency: checks bypass timing edge-exactly and debounce timing against a cycle bound.
// Backpressure: n/a; the bus never stalls.
module tb_digital_port_irq;
  import digital_port_irq_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] ioIn;
  logic        irq;
  logic [31:0] rd;
  int          checks;
  int          failures;

  digital_port_irq_if bus ();

  digital_port_irq #(
    .WIDTH         (32),
    .SYNC_STAGES   (2),
    .DEBOUNCE_BITS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ioIn  (ioIn),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipSelect  = 1'b1;
    bus.writeEnable = 1'b1;
    bus.address     = a;
    bus.dataIn      = d;
    @(negedge clk);
    bus.chipSelect  = 1'b0;
    bus.writeEnable = 1'b0;
    bus.address     = '0;
    bus.dataIn      = '0;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    bus.chipSelect  = 1'b1;
    bus.writeEnable = 1'b0;
    bus.address     = a;
    #1;
    d = bus.dataOut;
    bus.chipSelect  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ioIn  = 32'h0000_0080;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_level got=%h exp=00000000", rd); end
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=00000000", rd); end
    busRead(ADDR_DEBOUNCE, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_debounce got=%h exp=00000000", rd); end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    // Pin high out of reset looks like a rise, but no enables are set yet.
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL postreset_level got=%h exp=00000080", rd); end
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL postreset_pending got=%h exp=00000000", rd); end
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_bypass_rise;
    busWrite(ADDR_RISE_EN, 32'h0000_0001);
    ioIn = 32'h0000_0001;              // settled before edge k
    @(posedge clk); #1;                // after edge k
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rise_k0 got=%h exp=00000000", rd); end
    @(posedge clk); #1;                // after edge k+1
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL rise_k1 got=%h irq=%b exp=00000000 irq=0", rd, irq); end
    @(posedge clk); #1;                // after edge k+2
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h1 || irq !== 1'b1) begin failures++; $display("FAIL rise_k2 got=%h irq=%b exp=00000001 irq=1", rd, irq); end
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rise_level got=%h exp=00000001", rd); end
    busRead(ADDR_RISE_EN, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rise_en_rd got=%h exp=00000001", rd); end
  endtask

  task automatic test_fall_disabled_clear;
    @(negedge clk);
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL fall_level got=%h exp=00000000", rd); end
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h1 || irq !== 1'b1) begin failures++; $display("FAIL fall_no_set got=%h irq=%b exp=00000001 irq=1", rd, irq); end
    busWrite(ADDR_PENDING, 32'h0000_0001);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL w1c_clear got=%h irq=%b exp=00000000 irq=0", rd, irq); end
  endtask

  task automatic test_w1c_collision;
    busWrite(ADDR_RISE_EN, 32'h0000_0010);
    ioIn = 32'h0000_0010;
    repeat (4) @(negedge clk);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL coll_setup got=%h exp=00000010", rd); end
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
    // Rise enters sync before edge k, so stable rises on edge k+2; W1C is sampled on k+2 too.
    ioIn = 32'h0000_0010;
    @(negedge clk);
    busWrite(ADDR_PENDING, 32'h0000_0010);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL w1c_collision got=%h exp=00000010", rd); end
    busWrite(ADDR_PENDING, 32'h0000_0010);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_after got=%h exp=00000000", rd); end
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_unused_addr;
    busWrite(3'd5, 32'hFFFF_FFFF);
    for (int a = 5; a < 8; a++) begin
      busRead(3'(a), rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL unused_addr%0d got=%h exp=00000000", a, rd); end
    end
    bus.address = ADDR_RISE_EN;
    #1;
    checks++; if (bus.dataOut !== 32'h0) begin failures++; $display("FAIL idle_dataout got=%h exp=00000000", bus.dataOut); end
    bus.address = '0;
  endtask

  task automatic test_debounce;
    logic seenEarly;
    logic found;
    busWrite(ADDR_DEBOUNCE, 32'h1234_0004);
    busRead(ADDR_DEBOUNCE, rd);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL debounce_rd got=%h exp=00000004", rd); end
    repeat (10) @(negedge clk);
    ioIn = 32'h0000_0100;
    repeat (3) @(negedge clk);
    ioIn = 32'h0;
    seenEarly = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      busRead(ADDR_LEVEL, rd);
      if (rd[8]) seenEarly = 1'b1;
    end
    checks++; if (seenEarly !== 1'b0) begin failures++; $display("FAIL debounce_pulse got=%b exp=0", seenEarly); end
    @(negedge clk);
    ioIn  = 32'h0000_0100;
    found = 1'b0;
    for (int i = 0; i < 11 && !found; i++) begin
      @(posedge clk); #1;
      busRead(ADDR_LEVEL, rd);
      if (rd[8]) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL debounce_hold got=%b exp=1 within 11 cycles", found); end
    busWrite(ADDR_DEBOUNCE, 32'h0);
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_multi_bit;
    busWrite(ADDR_RISE_EN, 32'hFF00_FF00);
    busWrite(ADDR_FALL_EN, 32'h00FF_00FF);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL multi_start got=%h exp=00000000", rd); end
    ioIn = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'hFF00_FF00) begin failures++; $display("FAIL multi_step1 got=%h exp=ff00ff00", rd); end
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL multi_level1 got=%h exp=ffffffff", rd); end
    // Falls = ~0x12345678 = 0xEDCBA987, masked by 0x00FF00FF -> 0x00CB0087; OR 0xFF00FF00.
    ioIn = 32'h1234_5678;
    repeat (4) @(negedge clk);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'hFFCB_FF87) begin failures++; $display("FAIL multi_step2 got=%h exp=ffcbff87", rd); end
    busRead(ADDR_LEVEL, rd);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL multi_level2 got=%h exp=12345678", rd); end
  endtask

  task automatic test_async_reset;
    busWrite(ADDR_FALL_EN, 32'hFFFF_FFFF);
    ioIn = 32'h0;
    repeat (4) @(negedge clk);
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'hFFFF_FFFF || irq !== 1'b1) begin failures++; $display("FAIL areset_setup got=%h irq=%b exp=ffffffff irq=1", rd, irq); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL areset_irq got=%b exp=0", irq); end
    busRead(ADDR_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL areset_pending got=%h exp=00000000", rd); end
    busRead(ADDR_RISE_EN, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL areset_rise_en got=%h exp=00000000", rd); end
    busRead(ADDR_FALL_EN, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL areset_fall_en got=%h exp=00000000", rd); end
    checks++; if (bus.dataOut !== 32'h0) begin failures++; $display("FAIL areset_dataout got=%h exp=00000000", bus.dataOut); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    ioIn            = 32'h0;
    bus.chipSelect  = 1'b0;
    bus.writeEnable = 1'b0;
    bus.address     = '0;
    bus.dataIn      = '0;
    test_reset();
    test_bypass_rise();
    test_fall_disabled_clear();
    test_w1c_collision();
    test_unused_addr();
    test_debounce();
    test_multi_bit();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
